fp_compare_pipe: RTL and testbench

//  Multi-lane, pipelined comparator for FloPoCo-format floats (2 exn bits, sign, wE exp, wF frac).

---
 rtl/fp_compare_pipe.sv | 237 +++++++++++++++++++++++
 tb/tb_fp_compare_pipe.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_compare_pipe.sv
// fp_compare_pipe: multi-lane, two-stage comparator for FloPoCo-format floats
// ({exn[1:0], sign, exp[WE-1:0], frac[WF-1:0]}). The comparison works on the
// encoding itself, so zeros, infinities and NaNs are handled exactly.
// Optional feature macro: FPCMP_MINMAX_EN adds per-lane min/max outputs.

// One lane: stage-1 key compare, stage-2 predicate resolution.
module fp_compare_lane #(
   parameter int WE = 5,
   parameter int WF = 11,
   parameter int W  = WF + WE + 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ld1_i,    // capture new operands into stage 1
   input  logic         ld2_i,    // move stage 1 into stage 2
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic [2:0]   mode_i,   // predicate of the transaction held in stage 1
   output logic         res_o,
   output logic         unord_o
`ifdef FPCMP_MINMAX_EN
   ,
   output logic [W-1:0] min_o,
   output logic [W-1:0] max_o
`endif
);
   localparam int KW = WE + WF + 2;

   logic [KW-1:0] ka, kb;
   logic          mag_lt_d, mag_eq_d, za_d, zb_d, nan_d;
   logic          mag_lt_q, mag_eq_q, sa_q, sb_q, za_q, zb_q, nan_q;
   logic          lt, eq, gt, res_d, res_q, unord_q;
`ifdef FPCMP_MINMAX_EN
   logic [W-1:0]  a_q, b_q, min_d, max_d, min_q, max_q;
`endif

   // Magnitude key: zero < any normal < infinity; exp/frac only matter for normals.
   always_comb begin
      ka = {a_i[W-1:W-2], {(WE+WF){1'b0}}};
      kb = {b_i[W-1:W-2], {(WE+WF){1'b0}}};
      if (a_i[W-1:W-2] == 2'b01) ka = {2'b01, a_i[WE+WF-1:0]};
      if (b_i[W-1:W-2] == 2'b01) kb = {2'b01, b_i[WE+WF-1:0]};
      mag_lt_d = ka < kb;
      mag_eq_d = ka == kb;
      za_d     = a_i[W-1:W-2] == 2'b00;
      zb_d     = b_i[W-1:W-2] == 2'b00;
      nan_d    = (a_i[W-1:W-2] == 2'b11) || (b_i[W-1:W-2] == 2'b11);
   end

   // Stage 1 registers; hold their contents across bubbles and stalls.
   always_ff @(posedge clk) begin
      if (!rst) begin
         mag_lt_q <= 1'b0;
         mag_eq_q <= 1'b0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         za_q     <= 1'b0;
         zb_q     <= 1'b0;
         nan_q    <= 1'b0;
`ifdef FPCMP_MINMAX_EN
         a_q      <= '0;
         b_q      <= '0;
`endif
      end else if (ld1_i) begin
         mag_lt_q <= mag_lt_d;
         mag_eq_q <= mag_eq_d;
         sa_q     <= a_i[W-3];
         sb_q     <= b_i[W-3];
         za_q     <= za_d;
         zb_q     <= zb_d;
         nan_q    <= nan_d;
`ifdef FPCMP_MINMAX_EN
         a_q      <= a_i;
         b_q      <= b_i;
`endif
      end
   end

   // Signed ordering from sign bits and magnitude order, then predicate select.
   always_comb begin
      lt = 1'b0;
      eq = 1'b0;
      if (za_q && zb_q) begin
         eq = 1'b1;                       // +0 == -0
      end else if (sa_q != sb_q) begin
         lt = sa_q;                       // the negative operand is smaller
      end else if (sa_q) begin
         lt = !mag_lt_q && !mag_eq_q;     // both negative: magnitude order flips
         eq = mag_eq_q;
      end else begin
         lt = mag_lt_q;
         eq = mag_eq_q;
      end
      gt = !lt && !eq;
      case (mode_i)
         3'b000:  res_d = gt;
         3'b001:  res_d = gt || eq;
         3'b010:  res_d = lt;
         3'b011:  res_d = lt || eq;
         3'b100:  res_d = eq;
         3'b101:  res_d = !eq;
         default: res_d = 1'b0;
      endcase
      // Unordered: only NE holds.
      if (nan_q) res_d = (mode_i == 3'b101);
`ifdef FPCMP_MINMAX_EN
      if (nan_q) begin
         min_d = {2'b11, {(W-2){1'b0}}};
         max_d = {2'b11, {(W-2){1'b0}}};
      end else if (eq) begin
         min_d = a_q;
         max_d = a_q;
      end else if (lt) begin
         min_d = a_q;
         max_d = b_q;
      end else begin
         min_d = b_q;
         max_d = a_q;
      end
`endif
   end

   // Stage 2 (output) registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         res_q   <= 1'b0;
         unord_q <= 1'b0;
`ifdef FPCMP_MINMAX_EN
         min_q   <= '0;
         max_q   <= '0;
`endif
      end else if (ld2_i) begin
         res_q   <= res_d;
         unord_q <= nan_q;
`ifdef FPCMP_MINMAX_EN
         min_q   <= min_d;
         max_q   <= max_d;
`endif
      end
   end

   assign res_o   = res_q;
   assign unord_o = unord_q;
`ifdef FPCMP_MINMAX_EN
   assign min_o   = min_q;
   assign max_o   = max_q;
`endif
endmodule

module fp_compare_pipe #(
   parameter int WE    = 5,
   parameter int WF    = 11,
   parameter int LANES = 3,
   parameter int TAG_W = 4,
   parameter int W     = WF + WE + 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [LANES*W-1:0] in_a,
   input  logic [LANES*W-1:0] in_b,
   input  logic [2:0]         in_mode,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [LANES-1:0]   out_res,
   output logic               out_any,
   output logic               out_all,
   output logic [LANES-1:0]   out_unord,
   output logic [TAG_W-1:0]   out_tag
`ifdef FPCMP_MINMAX_EN
   ,
   output logic [LANES*W-1:0] out_min,
   output logic [LANES*W-1:0] out_max
`endif
);
   logic [LANES-1:0][W-1:0] a_v, b_v;
   logic [1:0]              vld_q;      // [0] stage 1, [1] output stage
   logic [2:0]              mode_q;
   logic [TAG_W-1:0]        tag1_q, tag2_q;
   logic                    stall, ld1, ld2;

   assign a_v   = in_a;
   assign b_v   = in_b;
   assign stall = vld_q[1] && !out_ready;
   assign ld1   = in_valid && !stall;
   assign ld2   = vld_q[0] && !stall;

   // Valid shift register plus the per-transaction mode/tag sideband.
   always_ff @(posedge clk) begin
      if (!rst) begin
         vld_q  <= 2'b00;
         mode_q <= 3'b000;
         tag1_q <= '0;
         tag2_q <= '0;
      end else if (!stall) begin
         vld_q <= {vld_q[0], in_valid};
         if (in_valid) begin
            mode_q <= in_mode;
            tag1_q <= in_tag;
         end
         if (vld_q[0]) tag2_q <= tag1_q;
      end
   end

`ifdef FPCMP_MINMAX_EN
   logic [LANES-1:0][W-1:0] min_v, max_v;
   assign out_min = min_v;
   assign out_max = max_v;
`endif

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      fp_compare_lane #(.WE(WE), .WF(WF), .W(W)) u_lane (
         .clk     (clk),
         .rst     (rst),
         .ld1_i   (ld1),
         .ld2_i   (ld2),
         .a_i     (a_v[i]),
         .b_i     (b_v[i]),
         .mode_i  (mode_q),
         .res_o   (out_res[i]),
         .unord_o (out_unord[i])
`ifdef FPCMP_MINMAX_EN
         ,
         .min_o   (min_v[i]),
         .max_o   (max_v[i])
`endif
      );
   end

   assign in_ready  = !stall;
   assign out_valid = vld_q[1];
   assign out_tag   = tag2_q;
   assign out_any   = |out_res;
   assign out_all   = &out_res;
endmodule

// File: tb/tb_fp_compare_pipe.sv
// Scoreboard bench for fp_compare_pipe: directed cases plus randomized traffic
// with random bubbles and backpressure, checked against a real-valued model.
module tb_fp_compare_pipe;
   localparam int WE = 5, WF = 11, W = WF + WE + 3, LANES = 3, TAG_W = 4;
   localparam logic [W-1:0] ONE = 19'h27800, TWO = 19'h28000, MONE = 19'h37800,
                            PZ = 19'h00000, NZ = 19'h10000, PINF = 19'h40000, QNAN = 19'h60000;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_any, out_all;
   logic [LANES*W-1:0] in_a = '0, in_b = '0;
   logic [2:0] in_mode = '0;
   logic [TAG_W-1:0] in_tag = '0, out_tag;
   logic [LANES-1:0] out_res, out_unord;
`ifdef FPCMP_MINMAX_EN
   logic [LANES*W-1:0] out_min, out_max;
`endif

   always #5 clk = ~clk;

   fp_compare_pipe #(.WE(WE), .WF(WF), .LANES(LANES), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
      .out_any(out_any), .out_all(out_all), .out_unord(out_unord), .out_tag(out_tag)
`ifdef FPCMP_MINMAX_EN
      , .out_min(out_min), .out_max(out_max)
`endif
   );

   typedef struct {
      logic [LANES-1:0]   res, unord;
      logic               any, all;
      logic [TAG_W-1:0]   tag;
      logic [LANES*W-1:0] mn, mx;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int n_cmp = 0, n_err = 0;
   bit rnd_done;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Numeric value of an encoding; infinity as a huge finite number.
   function automatic real fval(input logic [W-1:0] x);
      int ex, fr;
      real m;
      ex = int'(x[WE+WF-1:WF]);
      fr = int'(x[WF-1:0]);
      case (x[W-1:W-2])
         2'b00:   m = 0.0;
         2'b01:   m = (1.0 + fr / (2.0 ** WF)) * (2.0 ** (ex - 15));
         default: m = 1.0e300;
      endcase
      return x[W-3] ? -m : m;
   endfunction

   function automatic logic pred(input real va, input real vb, input logic nan, input logic [2:0] m);
      if (nan) return m == 3'd5;
      case (m)
         3'd0: return va > vb;
         3'd1: return va >= vb;
         3'd2: return va < vb;
         3'd3: return va <= vb;
         3'd4: return va == vb;
         3'd5: return va != vb;
         default: return 1'b0;
      endcase
   endfunction

   function automatic exp_t model(input logic [LANES-1:0][W-1:0] a, input logic [LANES-1:0][W-1:0] b,
                                  input logic [2:0] m, input logic [TAG_W-1:0] t);
      exp_t e;
      real va, vb;
      logic nan;
      e.res = '0; e.unord = '0; e.tag = t; e.mn = '0; e.mx = '0;
      for (int i = 0; i < LANES; i++) begin
         va  = fval(a[i]);
         vb  = fval(b[i]);
         nan = (a[i][W-1:W-2] == 2'b11) || (b[i][W-1:W-2] == 2'b11);
         e.unord[i] = nan;
         e.res[i]   = pred(va, vb, nan, m);
         if (nan) begin
            e.mn[i*W +: W] = QNAN; e.mx[i*W +: W] = QNAN;
         end else if (va == vb) begin
            e.mn[i*W +: W] = a[i]; e.mx[i*W +: W] = a[i];
         end else if (va < vb) begin
            e.mn[i*W +: W] = a[i]; e.mx[i*W +: W] = b[i];
         end else begin
            e.mn[i*W +: W] = b[i]; e.mx[i*W +: W] = a[i];
         end
      end
      e.any = |e.res;
      e.all = &e.res;
      return e;
   endfunction

   // Present one transaction, wait for acceptance (bounded), record expectation.
   task automatic send(input logic [LANES-1:0][W-1:0] a, input logic [LANES-1:0][W-1:0] b,
                       input logic [2:0] m, input logic [TAG_W-1:0] t);
      int k;
      @(negedge clk);
      in_a = a; in_b = b; in_mode = m; in_tag = t; in_valid = 1'b1;
      #1;
      k = 0;
      while (!in_ready && k < 100) begin
         @(negedge clk); #1; k++;
      end
      if (!in_ready) begin
         n_cmp++; n_err++;
         $display("FAIL send_timeout: in_ready stuck at 0 for tag %0h", t);
         in_valid = 1'b0;
         return;
      end
      q.push_back(model(a, b, m, t));
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int k = 0;
      while (q.size() != 0 && k < 300) begin
         @(negedge clk); k++;
      end
      chk("drain_left", 64'(q.size()), 64'd0);
   endtask

   function automatic logic [W-1:0] rnd_op();
      logic [W-1:0] r;
      r = W'($urandom);
      case ($urandom % 8)
         0: r[W-1:W-2] = 2'b00;
         1: begin r[W-1:W-2] = 2'b10; r[W-4:0] = '0; end
         2: r[W-1:W-2] = 2'b11;
         default: r[W-1:W-2] = 2'b01;
      endcase
      return r;
   endfunction

   // Monitor: pops and compares on every output transfer; in_ready rule each cycle.
   always @(negedge clk) begin
      #2;
      if (rst) begin
         chk("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL unexpected_out: tag %0h emerged with nothing expected", out_tag);
            end else begin
               mon_e = q.pop_front();
               chk("out_tag",   64'(out_tag),   64'(mon_e.tag));
               chk("out_res",   64'(out_res),   64'(mon_e.res));
               chk("out_unord", 64'(out_unord), 64'(mon_e.unord));
               chk("out_any",   64'(out_any),   64'(mon_e.any));
               chk("out_all",   64'(out_all),   64'(mon_e.all));
`ifdef FPCMP_MINMAX_EN
               chk("out_min",   64'(out_min),   64'(mon_e.mn));
               chk("out_max",   64'(out_max),   64'(mon_e.mx));
`endif
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [LANES-1:0][W-1:0] a, b;
      exp_t e;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk); #2;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_res",   64'(out_res),   64'd0);
      chk("rst_out_unord", 64'(out_unord), 64'd0);
      chk("rst_out_any",   64'(out_any),   64'd0);
      chk("rst_out_all",   64'(out_all),   64'd0);
      chk("rst_out_tag",   64'(out_tag),   64'd0);
      rst = 1'b1;

      // 1: GT across three lanes, plus latency
      a = {ONE, ONE, TWO}; b = {ONE, TWO, ONE};
      send(a, b, 3'd0, 4'h1);
      @(negedge clk); in_valid = 1'b0; #2;
      chk("lat_not_yet", 64'(out_valid), 64'd0);
      @(negedge clk); #2;
      chk("lat_valid", 64'(out_valid), 64'd1);
      chk("t1_res", 64'(out_res), 64'b001);
      idle(2);

      // 2: signed zero, sign-differing, infinity
      send({3{PZ}},   {3{NZ}},  3'd4, 4'h2);
      send({3{MONE}}, {3{PZ}},  3'd2, 4'h3);
      send({3{PINF}}, {3{TWO}}, 3'd1, 4'h4);
      // 3: NaN in every predicate
      for (int m = 0; m < 6; m++) send({3{QNAN}}, {3{ONE}}, 3'(m), 4'(m + 5));
      send({QNAN, ONE, ONE}, {ONE, ONE, TWO}, 3'd6, 4'hB);
      idle(1);
      drain();

      // 4: back-to-back stream with backpressure
      fork
         for (int i = 0; i < 8; i++) send({3{TWO}}, {ONE, TWO, MONE}, 3'd1, 4'(i));
         begin
            repeat (3) @(negedge clk);
            out_ready = 1'b0;
            repeat (3) @(negedge clk);
            out_ready = 1'b1;
         end
      join
      idle(1);
      drain();

      // 5: reset with two transactions in flight
      send({3{ONE}}, {3{TWO}}, 3'd2, 4'hC);
      @(negedge clk);
      out_ready = 1'b0;
      in_a = {3{TWO}}; in_b = {3{ONE}}; in_mode = 3'd0; in_tag = 4'hD; in_valid = 1'b1;
      #1;
      chk("t5_accept", 64'(in_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; rst = 1'b0;
      q.delete();
      @(negedge clk);
      rst = 1'b1; out_ready = 1'b1;
      #2;
      chk("t5_out_valid", 64'(out_valid), 64'd0);
      chk("t5_out_res",   64'(out_res),   64'd0);
      chk("t5_out_tag",   64'(out_tag),   64'd0);
      idle(6);

`ifdef FPCMP_MINMAX_EN
      // 6: min/max
      send({3{MONE}}, {3{TWO}}, 3'd0, 4'h6);
      send({QNAN, PZ, MONE}, {ONE, NZ, ONE}, 3'd4, 4'h7);
      idle(1);
      drain();
`endif

      // Randomized traffic with bubbles and backpressure
      rnd_done = 1'b0;
      fork
         begin
            for (int n = 0; n < 300; n++) begin
               for (int i = 0; i < LANES; i++) begin
                  a[i] = rnd_op();
                  case ($urandom % 8)
                     0, 1: b[i] = a[i];
                     2:    b[i] = a[i] ^ (W'(1) << (W - 3));
                     default: b[i] = rnd_op();
                  endcase
               end
               if ($urandom % 4 == 0) idle(1);
               send(a, b, 3'($urandom), 4'($urandom));
            end
            idle(1);
            rnd_done = 1'b1;
         end
         while (!rnd_done) begin
            @(negedge clk);
            out_ready = ($urandom % 4) != 0;
         end
      join
      @(negedge clk);
      out_ready = 1'b1;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
